// File: rtl/wb_arbiter_if.sv
// Bus bundle between the register-file write arbiter and its issuers (ALU, load unit, decode).
interface wb_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wd;
  logic [CW-1:0]   count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
    input  ld_ready, hazard, we, waddr, wd, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
    output ld_ready, hazard, we, waddr, wd, count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, load results wait in a FIFO,
// decode gets a hazard flag for any write still queued or on the write port.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic            ld_ready_c;
  logic            alu_win;
  logic            enq;
  logic            deq;
  logic            hazard_c;
  logic [PW-1:0]   off;

  // Arbitration, queue bookkeeping and next write-port contents.
  always_comb begin
    ld_ready_c = rst | (count_q < CW'(DEPTH));
    alu_win    = bus.alu_valid && (bus.alu_rd != 5'd0);
    deq        = !alu_win && (count_q != '0);
    enq        = !rst && bus.ld_valid && ld_ready_c && (bus.ld_rd != 5'd0);

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    if (alu_win) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_rd;
      wd_d    = bus.alu_data;
    end else if (deq) begin
      we_d    = 1'b1;
      waddr_d = mem_q[rptr_q].rd;
      wd_d    = mem_q[rptr_q].data;
    end

    // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
    wptr_d  = enq ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = deq ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  // Hazard: slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    hazard_c = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr_q;
      if (({1'b0, off} < count_q) &&
          (((bus.rs1 != 5'd0) && (bus.rs1 == mem_q[i].rd)) ||
           ((bus.rs2 != 5'd0) && (bus.rs2 == mem_q[i].rd)))) begin
        hazard_c = 1'b1;
      end
    end
    if (we_q && (((bus.rs1 != 5'd0) && (bus.rs1 == waddr_q)) ||
                 ((bus.rs2 != 5'd0) && (bus.rs2 == waddr_q)))) begin
      hazard_c = 1'b1;
    end
    if (rst) begin
      hazard_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wd_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wd_q    <= wd_d;
    end
  end

  // Queue storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wptr_q] <= '{rd: bus.ld_rd, data: bus.ld_data};
    end
  end

  assign bus.ld_ready = ld_ready_c;
  assign bus.hazard   = hazard_c;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wd       = wd_q;
  assign bus.count    = count_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, load-result queue entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; port list as below.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 alu_valid  in  1  single-cycle ALU result present this cycle.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_data  in  XLEN  ALU result.
REQ-009 ld_valid  in  1  load result offered.
REQ-010 ld_ready  out  1  queue can accept a load result this cycle.
REQ-011 ld_rd  in  5  load destination register.
REQ-012 ld_data  in  XLEN  load result.
REQ-013 rs1, rs2  in  5 each  source registers being read by decode.
REQ-014 hazard  out  1  rs1 or rs2 has a write still queued or in flight.
REQ-015 we  out  1  register file write enable.
REQ-016 waddr  out  5  register file write address.
REQ-017 wd  out  XLEN  register file write data.
REQ-018 count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 Load handshake: transfer when ld_valid && ld_ready at a rising edge; ld_rd/ld_data SHALL be enqueued at that edge.
REQ-020 ld_ready SHALL equal (count < DEPTH), combinational from count only; no pass-through when full.
REQ-021 A load transfer with ld_rd == 0 SHALL complete the handshake but not be enqueued.
REQ-022 Arbitration per cycle: valid ALU result with alu_rd != 0 wins the write port; otherwise the queue head is written if count > 0; otherwise idle.
REQ-023 ALU result with alu_rd == 0 SHALL be ignored and SHALL NOT block the queue that cycle.
REQ-024 Write port SHALL be registered: winner selected in cycle N drives we=1, waddr, wd in cycle N+1; we=0 when no winner.
REQ-025 Data value zero SHALL be written like any other value; only rd == 0 suppresses writes.
REQ-026 ALU latency to we = 1 cycle; load latency to we = at least 2 cycles (enqueue, then dequeue), more under ALU contention.
REQ-027 Queue SHALL be strict FIFO; loads written in acceptance order.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-029 Enqueue when full SHALL not occur (ld_ready=0); dequeue when empty SHALL not occur.
REQ-030 hazard SHALL be combinational: 1 when rs1 != 0 or rs2 != 0 matches the rd of any occupied queue entry or waddr while we=1; rs == 0 never flags.
REQ-031 hazard SHALL NOT consider the current-cycle ALU input.
REQ-032 Ordering between ALU and queued load writes to the same rd is the issuer's responsibility; hazard is the only indication.

Reset
REQ-033 On rst at a rising edge: count=0, pointers=0, we=0, waddr=0, wd=0; queue contents need not be cleared.
REQ-034 While rst is high, ld_ready SHALL be 1 but no transfer SHALL be recorded; hazard SHALL be 0.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight writes; no write after rst deasserts until a new winner.

Verification
REQ-036 ALU only: alu_valid=1, rd=5, data=0x1234 in cycle 0 -> cycle 1 we=1, waddr=5, wd=0x00001234; cycle 2 we=0.
REQ-037 Contention: load rd=7 data=0xAA enqueued cycle 0; alu_valid with rd=3 in cycles 1-2 -> writes rd3 in cycles 2-3, rd7 in cycle 4, hazard for rs1=7 high cycles 1-4, low cycle 5.
REQ-038 Full: DEPTH=4, alu_valid held with rd!=0, 5 loads offered -> ld_ready=0 after 4th, count=4; release ALU -> loads written in order one per cycle, ld_ready returns to 1 one cycle after the first dequeue.
REQ-039 rd zero: load rd=0 accepted -> count stays 0, no write; ALU rd=0 with queued head -> head written next cycle; data 0 to rd=9 -> we=1, wd=0.
REQ-040 Reset mid-operation: count=3, we=1, rst pulsed one cycle -> next cycle count=0, we=0, hazard=0; no stale writes afterward.
REQ-041 Wrap: 3*DEPTH back-to-back loads with no ALU traffic -> every value written exactly once in order, count never exceeds DEPTH.
